// File: rtl/brc_nibble_seq.sv
// brc_nibble_seq: sequential branch comparator for the BRC stage.
// Streams the operands one nibble per cycle (LSB first) through a single
// 4-bit carry-lookahead slice computing rs1 + ~rs2 + 1. The inter-nibble carry
// and a running zero flag are held in registers. The branch flags come only
// from the adder path.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      synchronous active-low reset
//   i_start      request a compare; accepted in IDLE or DONE only
//   i_rs1_data   operand A, latched on accepted start
//   i_rs2_data   operand B, latched on accepted start
//   i_br_un      1 = unsigned compare, 0 = signed; latched on accepted start
//   o_busy       high while nibbles are being processed
//   o_valid      one-cycle pulse when o_br_less/o_br_equal are fresh
//   o_br_less    A < B under the latched signedness, held until next result
//   o_br_equal   A == B, held until next result
module brc_nibble_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_br_un,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_br_less,
    output logic             o_br_equal
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned CNTW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned IDXW = CNTW + 2;
    localparam logic [CNTW-1:0] LAST = CNTW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             un_q, un_d;
    logic             busy_d, valid_d, less_d, equal_d;

    // Adder slice signals
    logic [IDXW-1:0]  base;
    logic [3:0]       add_a, add_b, add_s, gen, prop;
    logic [3:0]       c;
    logic             add_co;

    // Operand nibble selection: A and ~B at the current nibble position
    always_comb begin
        base  = {cnt_q, 2'b00};
        add_a = a_q[base +: 4];
        add_b = ~b_q[base +: 4];
    end

    // 4-bit carry-lookahead slice: S/Co = A + B + Cin
    always_comb begin
        gen    = add_a & add_b;
        prop   = add_a ^ add_b;
        c[0]   = carry_q;
        c[1]   = gen[0] | (prop[0] & carry_q);
        c[2]   = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry_q);
        c[3]   = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
               | (prop[2] & prop[1] & prop[0] & carry_q);
        add_co = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
               | (prop[3] & prop[2] & prop[1] & gen[0])
               | (prop[3] & prop[2] & prop[1] & prop[0] & carry_q);
        add_s  = prop ^ c;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        a_d     = a_q;
        b_d     = b_q;
        un_d    = un_q;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        less_d  = o_br_less;
        equal_d = o_br_equal;

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d = RUN;
                    a_d     = i_rs1_data;
                    b_d     = i_rs2_data;
                    un_d    = i_br_un;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    zero_d  = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                carry_d = add_co;
                zero_d  = zero_q & (add_s == 4'd0);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    equal_d = zero_d;
                    // Differing signs decide a signed compare without the subtract
                    if (!un_q && (a_q[WIDTH-1] != b_q[WIDTH-1])) begin
                        less_d = a_q[WIDTH-1];
                    end else begin
                        less_d = ~add_co;
                    end
                end else begin
                    cnt_d  = cnt_q + CNTW'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            un_q       <= 1'b0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            a_q        <= a_d;
            b_q        <= b_d;
            un_q       <= un_d;
            o_busy     <= busy_d;
            o_valid    <= valid_d;
            o_br_less  <= less_d;
            o_br_equal <= equal_d;
        end
    end

endmodule

// File: tb/tb_brc_nibble_seq.sv
// tb_brc_nibble_seq: directed vector table plus multi-cycle sequences for
// reset, abort, back-to-back streaming and a random sweep.
module tb_brc_nibble_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LAT   = 9;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic             br_un;
    logic             busy;
    logic             valid;
    logic             less;
    logic             equal;

    int errors = 0;
    int checks = 0;

    brc_nibble_seq #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_start    (start),
        .i_rs1_data (rs1),
        .i_rs2_data (rs2),
        .i_br_un    (br_un),
        .o_busy     (busy),
        .o_valid    (valid),
        .o_br_less  (less),
        .o_br_equal (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        un;
        logic        exp_less;
        logic        exp_equal;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_less(input logic [31:0] a, input logic [31:0] b, input logic u);
        if (u) return (a < b);
        return ($signed(a) < $signed(b));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One compare: start at an idle/done point, count edges from the
    // accepting edge (counted as 1) until o_valid is seen.
    task automatic run_cmp(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic u, input logic el, input logic ee);
        int n;
        logic held_less, held_eq;
        @(negedge clk);
        rs1 = a; rs2 = b; br_un = u; start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        rs1 = $urandom; rs2 = $urandom; br_un = ~u;
        check({name, " busy after accept"}, 32'(busy), 32'd1);
        while (!valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (start == 1'b0 && n == 4) start = 1'b1;
            if (n == 5) start = 1'b0;
        end
        check({name, " latency"}, 32'(n), 32'(LAT));
        check({name, " less"}, 32'(less), 32'(el));
        check({name, " equal"}, 32'(equal), 32'(ee));
        check({name, " busy with valid"}, 32'(busy), 32'd0);
        held_less = less;
        held_eq   = equal;
        @(posedge clk);
        @(negedge clk);
        check({name, " valid one cycle"}, 32'(valid), 32'd0);
        check({name, " hold"}, {30'd0, less, equal}, {30'd0, held_less, held_eq});
    endtask

    vec_t vecs[14];
    logic [31:0] ra[40];
    logic [31:0] rb[40];
    logic        ru[40];

    initial begin
        int nres;
        int pulses;
        logic [31:0] x, y;
        logic        u;

        rst_n = 1'b0; start = 1'b0; rs1 = '0; rs2 = '0; br_un = 1'b0;

        vecs[0]  = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h12345678, 32'h12345679, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{32'h80000000, 32'h80000001, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1};

        // Reset, then 20 idle cycles with everything low
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle outputs", {28'd0, busy, valid, less, equal}, 32'd0);
        end

        // Reset beats a simultaneous start
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; rs1 = 32'h1; rs2 = 32'h2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        check("reset vs start busy", 32'(busy), 32'd0);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].un,
                    vecs[i].exp_less, vecs[i].exp_equal);
        end

        // Abort mid-RUN: less is 1 beforehand, must be cleared, no valid
        run_cmp("pre-abort", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rs1 = 32'hABC; rs2 = 32'hABC; br_un = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort outputs", {28'd0, busy, valid, less, equal}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) pulses++;
        end
        check("abort no valid", 32'(pulses), 32'd0);

        // Back-to-back: start held, operands change every cycle
        nres = 0;
        for (int k = 0; k < 4 * LAT; k++) begin
            ra[k] = $urandom;
            rb[k] = ((k % 3) == 0) ? ra[k] : $urandom;
            ru[k] = 1'($urandom_range(0, 1));
            rs1 = ra[k]; rs2 = rb[k]; br_un = ru[k]; start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (valid && busy) check("b2b valid&busy", 32'd1, 32'd0);
            if (valid) begin
                check("b2b edge", 32'(k), 32'(LAT * nres + LAT - 1));
                check("b2b less", 32'(less),
                      32'(model_less(ra[LAT*nres], rb[LAT*nres], ru[LAT*nres])));
                check("b2b equal", 32'(equal), 32'(ra[LAT*nres] == rb[LAT*nres]));
                nres++;
            end
        end
        start = 1'b0;
        check("b2b results", 32'(nres), 32'd4);
        @(posedge clk);
        @(negedge clk);

        // Random sweep against a behavioural compare
        for (int i = 0; i < 200; i++) begin
            x = $urandom;
            y = ((i % 8) == 0) ? x : $urandom;
            if ((i % 16) == 5) y = x + 32'd1;
            u = 1'($urandom_range(0, 1));
            run_cmp("rand", x, y, u, model_less(x, y, u), x == y);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/brc_nibble_seq.md
# brc_nibble_seq

Area-reduced sequential branch comparator for the RISC-V core's BRC stage. It compares two WIDTH-bit register operands, signed or unsigned, by streaming one nibble per cycle, LSB first, through a single instance of the team's 4-bit carry-lookahead adder slice. The adder computes rs1 + ~rs2 + 1 and the block holds the inter-nibble carry in a register. It sits directly upstream of that adder slice, feeding its A/B/Cin and consuming S/Co, and reports br_less/br_equal to the branch-decision logic.

## Interface
- WIDTH, 32, operand width; must be a multiple of 4, minimum 8; NIB = WIDTH/4 nibble steps
- i_clk  in  1  clock; all state updates on its rising edge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  request a comparison; sampled only when the block can accept (IDLE or DONE)
- i_rs1_data  in  WIDTH  operand A; latched on accepted start
- i_rs2_data  in  WIDTH  operand B; latched on accepted start
- i_br_un  in  1  1 = unsigned compare, 0 = signed; latched on accepted start
- o_busy  out  1  high while in RUN
- o_valid  out  1  one-cycle pulse; result outputs are fresh in this cycle
- o_br_less  out  1  A < B under the latched signedness; held until the next result
- o_br_equal  out  1  A == B; held until the next result

## Operation
- Clock and reset: one clock (i_clk); reset (i_reset) is synchronous and active-low.
- States:
  - IDLE: waiting for a start.
  - RUN: processing nibbles; nibble counter cnt runs 0..NIB-1.
  - DONE: single cycle; results presented.
- Transitions:
  - IDLE → RUN on i_start=1. Latch the operands and i_br_un. Set cnt=0, carry=1, zero=1.
  - RUN: each edge feeds A[4cnt+3:4cnt] and ~B[4cnt+3:4cnt] to the adder slice, with Cin = carry. Then:
    - carry ← Co.
    - zero ← zero & (S == 0).
    - cnt ← cnt+1.
  - RUN → DONE on the edge that processes cnt = NIB-1. On that same edge, register the results:
    - o_br_equal ← final zero.
    - Unsigned: o_br_less ← ~Co_final.
    - Signed: o_br_less ← (A[WIDTH-1] ≠ B[WIDTH-1]) ? A[WIDTH-1] : ~Co_final.
  - DONE → RUN if i_start=1 (back-to-back comparisons); otherwise DONE → IDLE.
- i_start during RUN is ignored; no queueing, no error flag.
- Operand and i_br_un changes after the accepted start have no effect on the comparison in flight.
- Carry register width is 1 bit. The counter is ceil(log2(NIB)) bits and never wraps within a comparison, because RUN exits at NIB-1.
- Equality uses the zero flag, not operand XOR. The adder path alone must produce both flags.

## Timing
- Reset (i_reset=0 at an edge):
  - state=IDLE, o_busy=0, o_valid=0, o_br_less=0, o_br_equal=0.
  - cnt=0, carry=0, zero=0, operand registers cleared.
- Reset mid-RUN: the comparison is aborted and no o_valid is produced. Reset wins over a simultaneous i_start.
- Latency: start accepted at edge E0. o_busy is high for cycles E0..E(NIB). o_valid is high for exactly the cycle after edge E(NIB). For WIDTH=32, o_valid is high 9 edges after acceptance.
- Throughput: one result per NIB+1 cycles with i_start held high continuously.
- o_valid and o_busy are never high together.
- o_br_less/o_br_equal change only on the RUN → DONE edge and on reset.

## Test plan
- Reset then idle, 20 cycles with i_start=0: all outputs stay 0 and o_busy stays 0. Then assert reset during cycle 4 of RUN: o_valid never pulses and outputs are 0.
- Equality, WIDTH=32, A=B=0xDEADBEEF, i_br_un=0: o_valid on cycle 9 after start, o_br_equal=1, o_br_less=0.
- Signed vs unsigned, A=0xFFFFFFFF (−1), B=0x00000001:
  - signed: less=1, equal=0.
  - unsigned: less=0, equal=0.
- Carry chain across all nibbles, A=0x7FFFFFFF, B=0x80000000:
  - signed: less=0.
  - unsigned: less=1.
  - A=0x00000000 vs B=0x00000001 unsigned: less=1.
- Back-to-back with i_start held high and operands changing every cycle: results match the operands latched at each acceptance, o_valid pulses every 9 cycles, and starts during RUN are ignored.
- Random regression, 10k pairs with random i_br_un: o_br_less/o_br_equal match a behavioural $signed/$unsigned compare. Edge pairs 0x80000000/0x7FFFFFFF and 0/0 are forced.
